// File: rtl/pulse_scheduler_if.sv
// pulse_scheduler_if: requester-side bundle for the shared delayed-pulse timer.
//   req      : per-requester request level, held until the matching ack
//   delay_in : packed per-requester delays, slice i = [i*W +: W]
//   abort    : cancel of the running delay
//   ack      : one-hot, one-cycle acceptance strobe
//   fire     : one-hot, one-cycle delayed strobe to the owner
//   busy     : a delay is running
interface pulse_scheduler_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] delay_in;
    logic           abort;
    logic [N-1:0]   ack;
    logic [N-1:0]   fire;
    logic           busy;

    modport master (output req, delay_in, abort, input ack, fire, busy);
    modport slave  (input req, delay_in, abort, output ack, fire, busy);
endinterface

// File: rtl/pulse_scheduler.sv
// pulse_scheduler: one countdown counter shared round-robin by N requesters.
// Each accepted request yields a one-cycle fire strobe D+1 cycles after ack.
//   clk     : clock, all state changes on posedge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of pulse_scheduler_if (req/delay_in/abort in,
//             ack/fire/busy out, all outputs registered)
module pulse_scheduler #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    pulse_scheduler_if.slave   bus
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_COUNT
    } state_e;

    state_e          state_q;
    logic [W-1:0]    cnt_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   ptr_d;
    logic [N-1:0]    ack_q;
    logic [N-1:0]    fire_q;
    logic            busy_q;

    logic            gnt_vld_c;
    logic [IW-1:0]   gnt_idx_c;
    logic [W-1:0]    dly_c [N];

    // Unpack the per-requester delay slices.
    for (genvar g = 0; g < N; g++) begin : g_dly
        assign dly_c[g] = bus.delay_in[g*W +: W];
    end

    // Round-robin pick: first set req at ptr, ptr+1, ... mod N.
    always_comb begin : grant
        int unsigned k;
        k         = 0;
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        for (int unsigned off = 0; off < N; off++) begin
            k = (32'(ptr_q) + off) % N;
            if (!gnt_vld_c && bus.req[IW'(k)]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = IW'(k);
            end
        end
        ptr_d = IW'((32'(gnt_idx_c) + 32'd1) % N);
    end

    // Scheduler FSM; ack/fire are cleared every cycle so they pulse for one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
            fire_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            ack_q  <= '0;
            fire_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld_c) begin
                        ack_q[gnt_idx_c] <= 1'b1;
                        cnt_q            <= dly_c[gnt_idx_c];
                        owner_q          <= gnt_idx_c;
                        ptr_q            <= ptr_d;
                        busy_q           <= 1'b1;
                        state_q          <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    // Abort wins over an expiring count.
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        fire_q[owner_q] <= 1'b1;
                        busy_q          <= 1'b0;
                        state_q         <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack  = ack_q;
    assign bus.fire = fire_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// tb_pulse_scheduler: scoreboard bench for pulse_scheduler (N=4, W=8).
// Expected ack/fire events (vector + cycle) are queued as stimulus is driven
// and matched in order by a negedge monitor; busy/reset values checked inline.
module tb_pulse_scheduler;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    int unsigned t;
    int unsigned c;
    logic [39:0] exp_q[$];

    pulse_scheduler_if #(.N(N), .W(W)) bus ();

    pulse_scheduler #(.N(N), .W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [39:0] ev(input logic is_fire, input logic [3:0] vec,
                                       input int unsigned cy);
        return {cy, 3'b000, is_fire, vec};
    endfunction

    task automatic expect_ev(input logic is_fire, input logic [3:0] vec, input int unsigned cy);
        exp_q.push_back(ev(is_fire, vec, cy));
    endtask

    task automatic sb_pop(input string tag, input logic [39:0] got);
        if (exp_q.size() == 0) chk({tag, "_unexpected"}, 64'(got), 64'd0);
        else                   chk(tag, 64'(got), 64'(exp_q.pop_front()));
    endtask

    // Output monitor: every nonzero ack/fire must match the next queued event.
    always @(negedge clk) begin
        if (bus.ack != '0)  sb_pop("ack_event", ev(1'b0, bus.ack, cyc));
        if (bus.fire != '0) sb_pop("fire_event", ev(1'b1, bus.fire, cyc));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input int unsigned idx, input logic [7:0] d);
        bus.req[idx]            = 1'b1;
        bus.delay_in[idx*W +: W] = d;
    endtask

    // Bounded wait for ack[idx]; the requester drops req once it is seen.
    task automatic wait_ack(input int unsigned idx, input int budget);
        int n = 0;
        while (bus.ack[idx] !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk($sformatf("ack_seen%0d", idx), 64'(bus.ack[idx]), 64'd1);
        bus.req[idx] = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        bus.req      = '0;
        bus.delay_in = '0;
        bus.abort    = 1'b0;
        #1;
        chk("rst_ack",  64'(bus.ack),  64'd0);
        chk("rst_fire", 64'(bus.fire), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Single request, delay 3: ack T+1, busy T+1..T+4, fire T+5.
        t = cyc;
        set_req(2, 8'd3);
        expect_ev(1'b0, 4'b0100, t + 1);
        expect_ev(1'b1, 4'b0100, t + 5);
        wait_ack(2, 4);
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("busy_single_%0d", k), 64'(bus.busy), 64'(k <= 4));
            if (k < 5) tick(1);
        end
        tick(3);

        // Zero delay: fire the cycle right after ack, busy only in the ack cycle.
        t = cyc;
        set_req(0, 8'd0);
        expect_ev(1'b0, 4'b0001, t + 1);
        expect_ev(1'b1, 4'b0001, t + 2);
        wait_ack(0, 4);
        chk("busy_zero_ack", 64'(bus.busy), 64'd1);
        tick(1);
        chk("busy_zero_fire", 64'(bus.busy), 64'd0);
        tick(3);

        // Round-robin from reset: all four with delay 1, acks 3 cycles apart.
        do_reset();
        t = cyc;
        for (int unsigned g = 0; g < N; g++) set_req(g, 8'd1);
        for (int unsigned g = 0; g < N; g++) begin
            expect_ev(1'b0, 4'(1 << g), t + 1 + 3 * g);
            expect_ev(1'b1, 4'(1 << g), t + 3 + 3 * g);
        end
        for (int unsigned g = 0; g < N; g++) wait_ack(g, 8);
        tick(4);

        // Fairness after a grant to 3: pointer wrapped, so 0 beats 3.
        t = cyc;
        set_req(0, 8'd2);
        set_req(3, 8'd0);
        expect_ev(1'b0, 4'b0001, t + 1);
        expect_ev(1'b1, 4'b0001, t + 4);
        expect_ev(1'b0, 4'b1000, t + 5);
        expect_ev(1'b1, 4'b1000, t + 6);
        wait_ack(0, 4);
        wait_ack(3, 8);
        tick(3);

        // Abort 4 cycles after ack: no fire[1]; req[2] raised with abort is acked 2 later.
        t = cyc;
        set_req(1, 8'd10);
        expect_ev(1'b0, 4'b0010, t + 1);
        wait_ack(1, 4);
        tick(4);
        c = cyc;
        bus.abort = 1'b1;
        set_req(2, 8'd1);
        expect_ev(1'b0, 4'b0100, c + 2);
        expect_ev(1'b1, 4'b0100, c + 4);
        tick(1);
        bus.abort = 1'b0;
        chk("busy_after_abort", 64'(bus.busy), 64'd0);
        tick(1);
        chk("busy_regrant", 64'(bus.busy), 64'd1);
        wait_ack(2, 2);
        tick(15);

        // Reset at count 100 of a 255 delay: outputs clear at once, no fire.
        t = cyc;
        set_req(1, 8'd255);
        expect_ev(1'b0, 4'b0010, t + 1);
        wait_ack(1, 4);
        tick(100);
        chk("busy_pre_rst", 64'(bus.busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_ack",  64'(bus.ack),  64'd0);
        chk("rst_mid_fire", 64'(bus.fire), 64'd0);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        tick(1);
        reset_n = 1'b1;
        tick(300);

        // Pointer back at 0 after reset: requester 1 is granted before 2.
        t = cyc;
        set_req(1, 8'd0);
        set_req(2, 8'd0);
        expect_ev(1'b0, 4'b0010, t + 1);
        expect_ev(1'b1, 4'b0010, t + 2);
        expect_ev(1'b0, 4'b0100, t + 3);
        expect_ev(1'b1, 4'b0100, t + 4);
        wait_ack(1, 4);
        wait_ack(2, 6);
        tick(3);

        // Max delay uninterrupted: fire 256 cycles after ack.
        t = cyc;
        set_req(0, 8'd255);
        expect_ev(1'b0, 4'b0001, t + 1);
        expect_ev(1'b1, 4'b0001, t + 257);
        wait_ack(0, 4);
        tick(258);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
